logic_gate_unit: RTL
====================

// Module: logic_gate_unit
// PURPOSE
//   Parametrised successor to the single NAND cell: a WIDTH-bit bitwise logic unit
//   with six selectable ops, a valid/ready input, and a DEPTH-entry result FIFO.
//   Sits between the ui_in/uio_in pin decode and the uo_out drivers.
//   Keeps a saturating count of accepted operations for bring-up.
// PARAMETERS
//   WIDTH  8   operand/result width in bits (>=1)
//   DEPTH  4   result FIFO entries (power of two, >=2)
//   CNT_W  8   width of op_count (>=1)
// PORTS
//   clk        in   1            single clock; all state updates on rising edge
//   rst        in   1            synchronous, active-high reset
//   in_valid   in   1            operand beat present
//   in_ready   out  1            unit can accept a beat this cycle
//   in_a       in   WIDTH        operand A
//   in_b       in   WIDTH        operand B
//   in_op      in   3            op select (see BEHAVIOUR)
//   out_valid  out  1            FIFO head holds a result
//   out_ready  in   1            consumer takes the head this cycle
//   out_y      out  WIDTH        FIFO head result
//   out_zero   out  1            out_y == 0 (valid only with out_valid)
//   op_count   out  CNT_W        accepted beats, saturating
//   op_err     out  1            sticky illegal-op flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=1 at an edge): FIFO emptied, op_count=0, op_err=0. Outputs while
//     rst is high and on the first cycle after: out_valid=0, out_y=0, out_zero=0.
//     in_ready=0 while rst=1. Reset mid-stream drops all queued results.
//   - Ops, bitwise on in_a/in_b: 000 NAND, 001 AND, 010 NOR, 011 OR, 100 XOR,
//     101 XNOR, 110/111 reserved. Result is exactly WIDTH bits; no carries.
//   - Accept: in_valid & in_ready at an edge. The result is computed combinationally
//     and written to the FIFO tail on that edge.
//   - Latency: 1 cycle. If the FIFO was empty, out_valid=1 on the cycle after accept.
//   - in_ready = !full & !rst. There is no full-FIFO pass-through: a pop in the same
//     cycle does not raise in_ready.
//   - Pop: out_valid & out_ready at an edge advances the head. out_y holds steady
//     while out_valid=1 and out_ready=0.
//   - Simultaneous push and pop when neither full nor empty: occupancy is unchanged
//     and order is preserved.
//   - Push on empty with out_ready=1: no bypass. The result appears the next cycle.
//   - Read and write pointers are log2(DEPTH) bits plus a wrap bit.
//     full  = same index, wrap bits differ.  empty = pointers equal.
//   - out_y=0 and out_zero=0 whenever out_valid=0.
//   - op_count increments by 1 per accepted beat, including reserved ops.
//     It holds at 2^CNT_W-1 and never wraps.
// CONFIGURATION
//   LGU_OP_ERR_EN defined:
//     - Reserved ops 110/111 are still accepted but no FIFO entry is written.
//     - op_err sets on the accept edge and stays 1 until rst.
//   LGU_OP_ERR_EN undefined:
//     - Reserved ops execute as NAND and write a FIFO entry.
//     - op_err is tied to 0.
// TESTING (WIDTH=8, DEPTH=4, CNT_W=8 unless stated)
//   1 Reset, then A=0xF0, B=0xCC, op=000 for one beat -> next cycle
//     out_valid=1, out_y=0x3F, out_zero=0, op_count=1.
//   2 Six beats cycling ops 000..101 with A=0xAA, B=0x0F, out_ready=1 -> results in order
//     0xF5, 0x0A, 0x50, 0xAF, 0xA5, 0x5A.
//   3 out_ready=0, five beats offered -> four accepted, in_ready=0 after the fourth.
//     Then one pop -> in_ready=1 the next cycle.
//   4 FIFO holding two entries, push and pop in the same cycle -> occupancy stays 2
//     and FIFO order is preserved.
//   5 CNT_W=2, five accepted beats -> op_count reads 1,2,3,3,3.
//   6 op=110 with A=B=0xFF
//     -> with LGU_OP_ERR_EN: no result, op_err=1, op_count incremented.
//     -> without it: out_y=0x00, out_zero=1, op_err=0.
//     Then rst with 3 entries queued -> out_valid=0, op_count=0, op_err=0.

Source files
------------

// File: rtl/logic_gate_unit.sv
// WIDTH-bit bitwise logic unit (NAND/AND/NOR/OR/XOR/XNOR) with valid/ready input,
// DEPTH-entry result FIFO and saturating op counter. Optional macro: LGU_OP_ERR_EN.
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic [CNT_W-1:0] op_count,
   output logic             op_err
);

   localparam int IDX_W = $clog2(DEPTH);

   // Handshake: a beat transfers on any rising edge where valid and ready are both 1.
   logic [IDX_W:0]   wr_ptr;
   logic [IDX_W:0]   rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] head;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;

   always_comb begin
      result = ~(in_a & in_b);
      case (in_op)
         3'b000:  result = ~(in_a & in_b);
         3'b001:  result = in_a & in_b;
         3'b010:  result = ~(in_a | in_b);
         3'b011:  result = in_a | in_b;
         3'b100:  result = in_a ^ in_b;
         3'b101:  result = ~(in_a ^ in_b);
         default: result = ~(in_a & in_b);
      endcase
   end

   assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign empty    = (wr_ptr == rd_ptr);
   // No pass-through: a same-cycle pop never opens in_ready on a full FIFO.
   assign in_ready = !full && !rst;
   assign accept   = in_valid && in_ready;
   assign head     = mem[rd_ptr[IDX_W-1:0]];

   assign out_valid = !empty && !rst;
   assign out_y     = out_valid ? head : '0;
   assign out_zero  = out_valid && (head == '0);
   assign pop       = out_valid && out_ready;

`ifdef LGU_OP_ERR_EN
   logic reserved;
   assign reserved = in_op[2] & in_op[1];
   // Reserved ops are still accepted (and counted) but leave no FIFO entry.
   assign push     = accept && !reserved;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_err <= 1'b0;
      end else if (accept && reserved) begin
         op_err <= 1'b1;
      end
   end
`else
   assign push   = accept;
   assign op_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[IDX_W-1:0]] <= result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (accept && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + 1'b1;
      end
   end

endmodule
